// File: rtl/debug_link_pkg.sv
// Shared constants for the host side of the MIPS debug UART link:
// command bytes, command-op encodings, FSM states and dump geometry.
package debug_link_pkg;

    localparam logic [7:0] CmdStart       = 8'h01;
    localparam logic [7:0] CmdContinuos   = 8'h02;
    localparam logic [7:0] CmdStepByStep  = 8'h03;
    localparam logic [7:0] CmdReprogram   = 8'h05;
    localparam logic [7:0] CmdStep        = 8'h06;

    localparam int unsigned NbHeader      = 6;
    localparam int unsigned CantRegs      = 32;
    localparam int unsigned CantMemDatos  = 16;
    localparam int unsigned DumpWords     = NbHeader + CantRegs + CantMemDatos;

    typedef enum logic [1:0] {
        OpProgram  = 2'd0,
        OpRun      = 2'd1,
        OpStepMode = 2'd2,
        OpStep     = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        StIdle, StTxByte, StTxWait, StProgFetch, StProgByte, StRxDump
    } state_e;

    function automatic logic [7:0] first_cmd_byte(input cmd_op_e op);
        logic [7:0] b;
        b = CmdStep;
        unique case (op)
            OpProgram:  b = CmdReprogram;
            OpRun:      b = CmdContinuos;
            OpStepMode: b = CmdStepByStep;
            OpStep:     b = CmdStep;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_snapshot_buf.sv
// Reassembles the received dump byte stream (LSB first) into 32-bit words
// and holds them in a small word-addressed snapshot memory.
module debug_snapshot_buf
    import debug_link_pkg::*;
#(
    parameter int unsigned LEN      = 32,
    parameter int unsigned LEN_DATA = 8,
    parameter int unsigned WORDS    = DumpWords
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                byte_valid,
    input  logic [LEN_DATA-1:0] byte_in,
    input  logic                clear_idx,
    input  logic [5:0]          snap_addr,
    output logic [LEN-1:0]      snap_data,
    output logic                full
);

    localparam int unsigned BytesW = $clog2(LEN / LEN_DATA);
    localparam int unsigned IdxW   = $clog2(WORDS);
    localparam logic [BytesW-1:0] LastByte = BytesW'(LEN / LEN_DATA - 1);
    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(WORDS - 1);
    localparam logic [5:0]        LastAddr = 6'(WORDS - 1);

    logic [LEN-1:0]    mem [WORDS];
    logic [LEN-1:0]    asm_q, asm_d;
    logic [BytesW-1:0] byte_cnt_q;
    logic [IdxW-1:0]   word_idx_q;
    logic              full_q;
    logic              take, we;

    always_comb begin
        asm_d = {byte_in, asm_q[LEN-1:LEN_DATA]};
        // Bytes arriving after the last word are dropped rather than spilling.
        take  = byte_valid && !full_q;
        we    = take && (byte_cnt_q == LastByte);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q      <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            full_q     <= 1'b0;
        end else if (clear_idx) begin
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            full_q     <= 1'b0;
        end else if (take) begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_q + BytesW'(1);
            if (we) begin
                if (word_idx_q == LastIdx) full_q <= 1'b1;
                else                       word_idx_q <= word_idx_q + IdxW'(1);
            end
        end
    end

    // Storage is not reset so a snapshot survives a link reset.
    always_ff @(posedge clk) begin
        if (we) mem[word_idx_q] <= asm_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     snap_data <= '0;
        else if (snap_addr <= LastAddr) snap_data <= mem[snap_addr];
        else                            snap_data <= '0;
    end

    assign full = full_q;

endmodule

// File: rtl/debug_host_link.sv
// Host-side endpoint of the debug UART link: sends command bytes and the ROM
// program image, then collects the returned state dump into a snapshot buffer.
module debug_host_link
    import debug_link_pkg::*;
#(
    parameter int unsigned LEN                = 32,
    parameter int unsigned LEN_DATA           = 8,
    parameter int unsigned CANT_INSTRUCCIONES = 64,
    parameter int unsigned CANT_REGS          = CantRegs,
    parameter int unsigned CANT_MEM_DATOS     = CantMemDatos,
    parameter int unsigned NB_HEADER          = NbHeader,
    parameter int unsigned TIMEOUT            = 2_000_000
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cmd_valid,
    input  logic [1:0]                            cmd_op,
    output logic                                  cmd_ready,
    output logic [$clog2(CANT_INSTRUCCIONES)-1:0] prog_addr,
    input  logic [LEN-1:0]                        prog_data,
    output logic                                  tx_start,
    output logic [LEN_DATA-1:0]                   tx_data,
    input  logic                                  tx_done,
    input  logic                                  rx_done,
    input  logic [LEN_DATA-1:0]                   rx_data,
    input  logic [5:0]                            snap_addr,
    output logic [LEN-1:0]                        snap_data,
    output logic                                  dump_done,
    output logic [15:0]                           dump_count,
    output logic                                  busy,
    output logic                                  err
);

    localparam int unsigned AddrW    = $clog2(CANT_INSTRUCCIONES);
    localparam int unsigned TimeoutW = $clog2(TIMEOUT + 1);
    localparam int unsigned BytesW   = $clog2(LEN / LEN_DATA);
    localparam int unsigned Words    = NB_HEADER + CANT_REGS + CANT_MEM_DATOS;
    localparam logic [AddrW-1:0]    LastAddr    = AddrW'(CANT_INSTRUCCIONES - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT - 1);
    localparam logic [BytesW-1:0]   LastByte    = BytesW'(LEN / LEN_DATA - 1);

    state_e                state_q, state_d;
    cmd_op_e               op_q, op_d;
    logic                  cmd_idx_q, cmd_idx_d;
    logic                  in_prog_q, in_prog_d;
    logic                  halt_q, halt_d;
    logic [BytesW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [LEN-1:0]        word_q, word_d;
    logic [AddrW-1:0]      prog_addr_q, prog_addr_d;
    logic [TimeoutW-1:0]   to_q, to_d;
    logic                  tx_start_q, tx_start_d;
    logic [LEN_DATA-1:0]   tx_data_q, tx_data_d;
    logic                  err_q, err_d;
    logic                  dump_done_q, dump_done_d;
    logic [15:0]           dump_count_q, dump_count_d;
    logic                  clear_idx, byte_valid, full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            op_q         <= OpProgram;
            cmd_idx_q    <= 1'b0;
            in_prog_q    <= 1'b0;
            halt_q       <= 1'b0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            prog_addr_q  <= '0;
            to_q         <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            err_q        <= 1'b0;
            dump_done_q  <= 1'b0;
            dump_count_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cmd_idx_q    <= cmd_idx_d;
            in_prog_q    <= in_prog_d;
            halt_q       <= halt_d;
            byte_cnt_q   <= byte_cnt_d;
            word_q       <= word_d;
            prog_addr_q  <= prog_addr_d;
            to_q         <= to_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            err_q        <= err_d;
            dump_done_q  <= dump_done_d;
            dump_count_q <= dump_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cmd_idx_d    = cmd_idx_q;
        in_prog_d    = in_prog_q;
        halt_d       = halt_q;
        byte_cnt_d   = byte_cnt_q;
        word_d       = word_q;
        prog_addr_d  = prog_addr_q;
        to_d         = to_q;
        tx_start_d   = tx_start_q;
        tx_data_d    = tx_data_q;
        err_d        = err_q;
        dump_done_d  = 1'b0;
        dump_count_d = dump_count_q;
        clear_idx    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d        = cmd_op_e'(cmd_op);
                    err_d       = 1'b0;
                    cmd_idx_d   = 1'b0;
                    in_prog_d   = 1'b0;
                    prog_addr_d = '0;
                    tx_data_d   = first_cmd_byte(cmd_op_e'(cmd_op));
                    state_d     = StTxByte;
                end
            end
            StTxByte: begin
                tx_start_d = 1'b1;
                state_d    = StTxWait;
            end
            StTxWait: begin
                if (tx_done) begin
                    tx_start_d = 1'b0;
                    if (!in_prog_q) begin
                        if (op_q == OpProgram && !cmd_idx_q) begin
                            tx_data_d = CmdStart;
                            cmd_idx_d = 1'b1;
                            state_d   = StTxByte;
                        end else if (op_q == OpProgram) begin
                            in_prog_d = 1'b1;
                            state_d   = StProgFetch;
                        end else if (op_q == OpStepMode) begin
                            state_d = StIdle;
                        end else begin
                            to_d      = '0;
                            clear_idx = 1'b1;
                            state_d   = StRxDump;
                        end
                    end else if (byte_cnt_q != LastByte) begin
                        byte_cnt_d = byte_cnt_q + BytesW'(1);
                        tx_data_d  = word_q[LEN_DATA-1:0];
                        word_d     = word_q >> LEN_DATA;
                        state_d    = StTxByte;
                    end else if (halt_q) begin
                        state_d = StIdle;
                    end else if (prog_addr_q == LastAddr) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        prog_addr_d = prog_addr_q + AddrW'(1);
                        state_d     = StProgFetch;
                    end
                end
            end
            StProgFetch: state_d = StProgByte;
            StProgByte: begin
                // ROM word is valid now; byte 0 goes straight out to save a cycle.
                tx_data_d  = prog_data[LEN_DATA-1:0];
                word_d     = prog_data >> LEN_DATA;
                halt_d     = (prog_data[LEN-1 -: 6] == 6'h3F);
                byte_cnt_d = '0;
                tx_start_d = 1'b1;
                state_d    = StTxWait;
            end
            StRxDump: begin
                if (full) begin
                    dump_done_d  = 1'b1;
                    dump_count_d = dump_count_q + 16'd1;
                    state_d      = StIdle;
                end else if (rx_done) begin
                    to_d = '0;
                end else if (to_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    to_d = to_q + TimeoutW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == StIdle);
        busy       = (state_q != StIdle);
        byte_valid = rx_done && (state_q == StRxDump);
    end

    debug_snapshot_buf #(
        .LEN      (LEN),
        .LEN_DATA (LEN_DATA),
        .WORDS    (Words)
    ) u_snap (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_in    (rx_data),
        .clear_idx  (clear_idx),
        .snap_addr  (snap_addr),
        .snap_data  (snap_data),
        .full       (full)
    );

    assign prog_addr  = prog_addr_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign err        = err_q;
    assign dump_done  = dump_done_q;
    assign dump_count = dump_count_q;

endmodule

// File: tb/tb_debug_host_link.sv
// Directed bench for debug_host_link: models the ROM and the UART transmitter
// and feeds dump bytes by hand.
module tb_debug_host_link;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_ready;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data = '0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic [5:0]  snap_addr = '0;
    logic [31:0] snap_data;
    logic        dump_done;
    logic [15:0] dump_count;
    logic        busy;
    logic        err;

    logic [31:0] rom [64];
    logic [7:0]  txq [$];
    logic [7:0]  exp_prog [14];
    bit          tx_en = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int          dd_cnt = 0;

    debug_host_link #(.TIMEOUT(1000)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .snap_addr  (snap_addr),
        .snap_data  (snap_data),
        .dump_done  (dump_done),
        .dump_count (dump_count),
        .busy       (busy),
        .err        (err)
    );

    initial forever #5 clk = ~clk;

    // Synchronous ROM: data follows the address by one clock.
    initial forever begin
        @(posedge clk);
        #1 prog_data = rom[prog_addr];
    end

    // UART transmitter: record each requested byte, answer with tx_done.
    initial forever begin
        @(posedge clk);
        #1;
        if (tx_start && tx_en) begin
            txq.push_back(tx_data);
            repeat (2) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (dump_done) dd_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op);
        cmd_op    = op;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("accept_busy", busy, 1);
        check("tx_start_edge1", tx_start, 0);
        tick();
        check("tx_start_edge2", tx_start, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!cmd_ready && n < budget) begin
            tick();
            n++;
        end
        check(tag, cmd_ready, 1);
    endtask

    task automatic wait_tx(input string tag, input int count, input int budget);
        int n = 0;
        while (txq.size() < count && n < budget) begin
            tick();
            n++;
        end
        check(tag, txq.size() >= count, 1);
    endtask

    task automatic feed_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic read_snap(input string tag, input logic [5:0] a, input logic [31:0] exp);
        snap_addr = a;
        tick();
        check(tag, snap_data, exp);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = '0;
        rom[0] = 32'h2001_0005;
        rom[1] = 32'h2002_0007;
        rom[2] = 32'hFC00_0000;
        exp_prog = '{8'h05, 8'h01, 8'h05, 8'h00, 8'h01, 8'h20, 8'h07,
                     8'h00, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'hFC};

        // Reset values
        repeat (3) tick();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_prog_addr", prog_addr, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_dump_count", dump_count, 0);
        check("rst_err", err, 0);
        check("rst_snap_data", snap_data, 0);
        reset = 1'b1;
        tick();

        // PROGRAM with a 3-word ROM ending in a halt word
        txq.delete();
        issue(2'd0);
        wait_idle("prog_idle", 1000);
        check("prog_len", txq.size(), 14);
        if (txq.size() == 14)
            for (int i = 0; i < 14; i++) check("prog_byte", txq[i], exp_prog[i]);
        check("prog_err", err, 0);

        // Stray rx_done in IDLE must be ignored, then STEP with a full dump
        feed_byte(8'hAA);
        check("stray_rx_idle", cmd_ready, 1);
        txq.delete();
        issue(2'd3);
        wait_tx("step_tx", 1, 50);
        repeat (6) tick();
        check("step_byte", txq[0], 8'h06);
        check("step_rx_busy", busy, 1);
        for (int i = 0; i < 216; i++) begin
            feed_byte(8'(i));
            if (i != 215) tick();
        end
        check("step_dd_early", dump_done, 0);
        tick();
        check("step_dd_pulse", dump_done, 1);
        check("step_count", dump_count, 1);
        tick();
        check("step_dd_low", dump_done, 0);
        check("step_idle", cmd_ready, 1);
        check("step_dd_once", dd_cnt, 1);
        read_snap("snap_w0", 6'd0, 32'h0302_0100);
        read_snap("snap_w6", 6'd6, 32'h1B1A_1918);
        read_snap("snap_w53", 6'd53, 32'hD7D6_D5D4);

        // RUN with a command pulsed while the dump is in progress
        txq.delete();
        issue(2'd1);
        wait_tx("run_tx", 1, 50);
        repeat (6) tick();
        for (int i = 0; i < 50; i++) begin
            feed_byte(8'(i) ^ 8'h5A);
            tick();
        end
        cmd_op    = 2'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("busy_not_ready", cmd_ready, 0);
        repeat (5) tick();
        check("busy_tx_idle", txq.size(), 1);
        for (int i = 50; i < 216; i++) begin
            feed_byte(8'(i) ^ 8'h5A);
            tick();
        end
        tick();
        check("run_byte", txq[0], 8'h02);
        check("run_count", dump_count, 2);
        check("run_dd_cnt", dd_cnt, 2);
        check("run_idle", cmd_ready, 1);
        read_snap("run_snap_w0", 6'd0, 32'h5958_5B5A);

        // PROGRAM with no halt word: 64 words then error, no address wrap
        for (int i = 0; i < 64; i++) rom[i] = i;
        txq.delete();
        issue(2'd0);
        wait_idle("nohalt_idle", 5000);
        check("nohalt_len", txq.size(), 258);
        check("nohalt_err", err, 1);
        check("nohalt_addr", prog_addr, 63);

        // RUN that stalls after 100 bytes: timeout error, no dump_done
        txq.delete();
        issue(2'd1);
        check("err_cleared", err, 0);
        wait_tx("stall_tx", 1, 50);
        repeat (6) tick();
        for (int i = 0; i < 99; i++) begin
            feed_byte(8'(i));
            tick();
        end
        feed_byte(8'd99);
        repeat (999) tick();
        check("stall_err_before", err, 0);
        check("stall_busy_before", busy, 1);
        tick();
        check("stall_err", err, 1);
        check("stall_idle", cmd_ready, 1);
        check("stall_no_dd", dd_cnt, 2);
        check("stall_count", dump_count, 2);

        // Asynchronous reset while a STEP byte is waiting for tx_done
        tx_en = 1'b0;
        issue(2'd3);
        repeat (3) tick();
        check("rst_mid_tx_start", tx_start, 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_tx_low", tx_start, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", dump_count, 0);
        #2 reset = 1'b1;
        tick();
        tx_en = 1'b1;
        txq.delete();
        issue(2'd2);
        wait_idle("stepmode_idle", 200);
        repeat (3) tick();
        check("stepmode_len", txq.size(), 1);
        check("stepmode_byte", txq[0], 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
